mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single pipelined main-memory port between the instruction-cache miss path, the data-cache miss path and the write-through store path. For each granted miss it issues a full block of sequential read addresses, streams the returned words into the owning cache's fill port, and signals completion. Stores are single-cycle memory writes. The CPU stalls on `busy` or on an outstanding miss.

## Interface
- `LATENCY`, 4, memory read latency in cycles from `mem_en` (read) to `mem_valid`.
- `WORDS`, 8, 16-bit words per cache block; must be a power of two ≥ 2.
- `clk` in 1: clock, all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_miss` in 1: I-cache block miss, held until `i_done`.
- `i_addr` in 16: I-cache miss byte address.
- `d_miss` in 1: D-cache block miss, held until `d_done`.
- `d_addr` in 16: D-cache miss byte address.
- `st_req` in 1: store request, held until `st_ack`.
- `st_addr` in 16: store byte address.
- `st_data` in 16: store data.
- `st_ack` out 1: store accepted this cycle.
- `mem_en` out 1: memory access this cycle.
- `mem_wr` out 1: 1 = write, 0 = read; meaningful only with `mem_en`.
- `mem_addr` out 16: memory byte address.
- `mem_wdata` out 16: memory write data.
- `mem_rdata` in 16: memory read data.
- `mem_valid` in 1: `mem_rdata` is valid this cycle.
- `fill_i_we` out 1: write `fill_data` into the I-cache at `fill_addr`.
- `fill_d_we` out 1: write `fill_data` into the D-cache at `fill_addr`.
- `fill_addr` out 16: byte address of the word being filled.
- `fill_data` out 16: equals `mem_rdata`.
- `i_done` out 1: one-cycle pulse with the last I-fill word.
- `d_done` out 1: one-cycle pulse with the last D-fill word.
- `busy` out 1: the state is not IDLE.

## Operation
- **States:** IDLE, STORE, FILL. A 1-bit `owner` register holds I or D while in FILL.
- **Grant in IDLE**, fixed priority `i_miss` > `d_miss` > `st_req`. No preemption once a state is entered.
- **Miss grant:**
  - latch `base = addr & ~(2*WORDS-1)` from the granted address;
  - set `owner`;
  - clear `issue_cnt` and `ret_cnt`;
  - next state FILL.
- **`st_req` grant:** latch `st_addr` and `st_data`; next state STORE.
- **STORE** (exactly one cycle):
  - `mem_en`=1, `mem_wr`=1, `mem_addr`/`mem_wdata` = latched values, `st_ack`=1;
  - next state IDLE.
- **FILL issue:** while `issue_cnt` < WORDS:
  - `mem_en`=1, `mem_wr`=0;
  - `mem_addr = base | (issue_cnt << 1)` (OR, never carries out of the block);
  - `issue_cnt` increments each cycle.
- **FILL return:** on `mem_valid`:
  - assert `fill_i_we` or `fill_d_we` per `owner`;
  - `fill_addr = base | (ret_cnt << 1)`, `fill_data = mem_rdata`;
  - `ret_cnt` increments.
- **FILL completion:** when `ret_cnt` == WORDS-1 and `mem_valid`:
  - assert the owner's done pulse in the same cycle as the last fill write;
  - next state IDLE.
- **Outside FILL:** `mem_valid` is ignored and no fill write-enable is asserted.
- **Counter widths:** `issue_cnt` is log2(WORDS)+1 bits; `ret_cnt` is log2(WORDS) bits.
- **Requester obligations:**
  - a requester drops its miss in the cycle after its done pulse;
  - a requester that is still requesting in IDLE is granted again by the priority rule.
- **Reset** (asynchronous, any state including mid-fill):
  - state IDLE, counters 0, `base` 0, `owner` I;
  - all outputs 0.
  - Memory shares reset, so no stale returns arrive after reset.

## Timing
- Miss asserted in IDLE cycle t: grant at edge end of t.
- Read issues in cycles t+1 … t+WORDS.
- Words return in cycles t+1+LATENCY … t+WORDS+LATENCY.
- Done pulse at t+WORDS+LATENCY, i.e. t+12 with the defaults. IDLE again at t+13.
- Store asserted in IDLE cycle t: `st_ack` and the memory write in t+1; IDLE at t+2.
- Issue and return overlap; no bubbles are inserted. `mem_en` is low once all WORDS reads are issued.
- Back-to-back requests: at least one IDLE cycle separates consecutive grants.

## Test plan
- **I-miss:** `i_miss` with `i_addr`=0x1236, memory returns word k = 0xA000+k.
  - Reads are issued to 0x1230, 0x1232 … 0x123E in 8 consecutive cycles.
  - `fill_i_we` fires 8 times with matching addresses and data.
  - `i_done` fires at t+12; `fill_d_we` never fires.
- **Simultaneous requests:** `i_miss`, `d_miss` and `st_req` asserted together.
  - I-fill completes first, then D-fill, then the store.
  - `st_ack` fires exactly once with the correct `mem_addr` and `mem_wdata`.
- **Store only:** `st_addr`=0x00F0, `st_data`=0xBEEF.
  - One cycle with `mem_en`=1, `mem_wr`=1 and `st_ack`=1; `busy` is low two cycles after the request.
- **Reset mid-fill:** `rst_n` pulled low after 3 words of a D-fill.
  - All outputs 0 immediately; state IDLE.
  - A new `d_miss` then fills all 8 words from word 0.
- **Stray valid:** `mem_valid` toggled while IDLE or in STORE.
  - No fill write-enable and no done pulse.
- **Block wrap:** `d_addr`=0xFFFE.
  - Addresses 0xFFF0 … 0xFFFE only; no overflow.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Pipelined main-memory port shared by the cache miss and store paths.
interface mem_arbiter_if;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic          en;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          valid;

    modport master (output en, wr, addr, wdata, input rdata, valid);
    modport slave  (input en, wr, addr, wdata, output rdata, valid);
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the memory port between I-miss, D-miss and store requesters;
// a miss issues a whole block of reads and streams the returns into the owner's fill port.
module mem_arbiter #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned WORDS   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_miss_i,
    input  logic [15:0]   i_addr_i,
    input  logic          d_miss_i,
    input  logic [15:0]   d_addr_i,
    input  logic          st_req_i,
    input  logic [15:0]   st_addr_i,
    input  logic [15:0]   st_data_i,
    output logic          st_ack_o,
    mem_arbiter_if.master mem,
    output logic          fill_i_we_o,
    output logic          fill_d_we_o,
    output logic [15:0]   fill_addr_o,
    output logic [15:0]   fill_data_o,
    output logic          i_done_o,
    output logic          d_done_o,
    output logic          busy_o
);
    localparam int unsigned AW   = 16;
    localparam int unsigned IDXW = $clog2(WORDS);
    localparam int unsigned CW   = IDXW + 1;
    localparam logic [AW-1:0]   BLK_MASK  = AW'(2 * WORDS - 1);
    localparam logic [CW-1:0]   ISSUE_END = CW'(WORDS);
    localparam logic [IDXW-1:0] RET_LAST  = IDXW'(WORDS - 1);

    if (WORDS < 2 || (WORDS & (WORDS - 1)) != 0 || LATENCY == 0) begin : g_param_check
        $error("mem_arbiter: WORDS must be a power of two >= 2 and LATENCY >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_STORE, S_FILL} state_e;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    logic [AW-1:0]   base_q, base_d;
    logic [CW-1:0]   issue_cnt_q, issue_cnt_d;
    logic [IDXW-1:0] ret_cnt_q, ret_cnt_d;
    logic [AW-1:0]   st_addr_q, st_addr_d;
    logic [15:0]     st_data_q, st_data_d;

    // Next-state and output decode; outputs only depend on registered state plus mem.valid/rdata.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        base_d      = base_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        st_addr_d   = st_addr_q;
        st_data_d   = st_data_q;
        mem.en      = 1'b0;
        mem.wr      = 1'b0;
        mem.addr    = '0;
        mem.wdata   = '0;
        st_ack_o    = 1'b0;
        fill_i_we_o = 1'b0;
        fill_d_we_o = 1'b0;
        fill_addr_o = '0;
        fill_data_o = mem.rdata;
        i_done_o    = 1'b0;
        d_done_o    = 1'b0;
        busy_o      = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (i_miss_i) begin
                    base_d      = i_addr_i & ~BLK_MASK;
                    owner_d     = OWN_I;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    state_d     = S_FILL;
                end else if (d_miss_i) begin
                    base_d      = d_addr_i & ~BLK_MASK;
                    owner_d     = OWN_D;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    state_d     = S_FILL;
                end else if (st_req_i) begin
                    st_addr_d = st_addr_i;
                    st_data_d = st_data_i;
                    state_d   = S_STORE;
                end
            end
            S_STORE: begin
                mem.en    = 1'b1;
                mem.wr    = 1'b1;
                mem.addr  = st_addr_q;
                mem.wdata = st_data_q;
                st_ack_o  = 1'b1;
                state_d   = S_IDLE;
            end
            S_FILL: begin
                // Issue and return overlap freely; OR-ing the offset keeps addresses inside the block.
                if (issue_cnt_q < ISSUE_END) begin
                    mem.en      = 1'b1;
                    mem.addr    = base_q | (AW'(issue_cnt_q[IDXW-1:0]) << 1);
                    issue_cnt_d = issue_cnt_q + CW'(1);
                end
                fill_addr_o = base_q | (AW'(ret_cnt_q) << 1);
                if (mem.valid) begin
                    fill_i_we_o = (owner_q == OWN_I);
                    fill_d_we_o = (owner_q == OWN_D);
                    ret_cnt_d   = ret_cnt_q + IDXW'(1);
                    if (ret_cnt_q == RET_LAST) begin
                        i_done_o = (owner_q == OWN_I);
                        d_done_o = (owner_q == OWN_D);
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_I;
            base_q      <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            st_addr_q   <= '0;
            st_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            st_addr_q   <= st_addr_d;
            st_data_q   <= st_data_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for idle/store/stray-valid cycles,
// hand sequences for block fills, priority, mid-fill reset and block wrap.
module tb_mem_arbiter;
    localparam int unsigned LATENCY = 4;
    localparam int unsigned WORDS   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_miss, d_miss, st_req;
    logic [15:0] i_addr, d_addr, st_addr, st_data;
    logic        st_ack, fill_i_we, fill_d_we, i_done, d_done, busy;
    logic [15:0] fill_addr, fill_data;
    logic        stray;
    logic [15:0] data_base;

    always #5 clk = ~clk;

    mem_arbiter_if mif ();

    mem_arbiter #(.LATENCY(LATENCY), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss_i(i_miss), .i_addr_i(i_addr),
        .d_miss_i(d_miss), .d_addr_i(d_addr),
        .st_req_i(st_req), .st_addr_i(st_addr), .st_data_i(st_data),
        .st_ack_o(st_ack), .mem(mif),
        .fill_i_we_o(fill_i_we), .fill_d_we_o(fill_d_we),
        .fill_addr_o(fill_addr), .fill_data_o(fill_data),
        .i_done_o(i_done), .d_done_o(d_done), .busy_o(busy)
    );

    // Memory model: fixed-latency read pipeline, word k of a block returns data_base + k.
    logic [LATENCY-1:0] pv;
    logic [15:0]        pa [LATENCY];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            for (int i = 0; i < int'(LATENCY); i++) pa[i] <= 16'h0;
        end else begin
            pv    <= {pv[LATENCY-2:0], mif.en & ~mif.wr};
            pa[0] <= mif.addr;
            for (int i = 1; i < int'(LATENCY); i++) pa[i] <= pa[i-1];
        end
    end
    assign mif.valid = pv[LATENCY-1] | stray;
    assign mif.rdata = pv[LATENCY-1] ? data_base + ((pa[LATENCY-1] >> 1) & 16'(WORDS - 1))
                                     : (stray ? 16'hDEAD : 16'h0000);

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;
    ev_t rd_q[$], wr_q[$], fi_q[$], fd_q[$], ev_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (mif.en && !mif.wr) rd_q.push_back('{cyc, mif.addr, 16'h0});
            if (mif.en &&  mif.wr) wr_q.push_back('{cyc, mif.addr, mif.wdata});
            if (fill_i_we) fi_q.push_back('{cyc, fill_addr, fill_data});
            if (fill_d_we) fd_q.push_back('{cyc, fill_addr, fill_data});
            if (i_done)    ev_q.push_back('{cyc, 16'd1, 16'h0});
            if (d_done)    ev_q.push_back('{cyc, 16'd2, 16'h0});
            if (st_ack)    ev_q.push_back('{cyc, 16'd3, 16'h0});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_q();
        rd_q.delete(); wr_q.delete(); fi_q.delete(); fd_q.delete(); ev_q.delete();
    endtask

    // Bounded wait for a done/ack pulse (1=i_done, 2=d_done, 3=st_ack), sampled at negedge.
    task automatic wait_ev(input int kind, input string name, output int at);
        logic found = 1'b0;
        at = -1;
        for (int n = 0; n < 80 && !found; n++) begin
            @(negedge clk);
            if ((kind == 1 && i_done) || (kind == 2 && d_done) || (kind == 3 && st_ack)) begin
                found = 1'b1;
                at = cyc;
            end
        end
        chk({name, "_seen"}, 64'(found), 64'd1);
    endtask

    task automatic check_fill(input bit is_d, input logic [15:0] base, input int t, input string name);
        ev_t fq[$];
        ev_t oq[$];
        if (is_d) begin fq = fd_q; oq = fi_q; end
        else      begin fq = fi_q; oq = fd_q; end
        chk({name, "_nreads"}, 64'(rd_q.size()), 64'(WORDS));
        chk({name, "_nfills"}, 64'(fq.size()), 64'(WORDS));
        chk({name, "_other_fills"}, 64'(oq.size()), 64'd0);
        for (int k = 0; k < rd_q.size() && k < int'(WORDS); k++) begin
            chk($sformatf("%s_rd%0d_addr", name, k), 64'(rd_q[k].addr), 64'(base + 16'(2 * k)));
            chk($sformatf("%s_rd%0d_cyc", name, k), 64'(rd_q[k].cyc), 64'(t + 1 + k));
        end
        for (int k = 0; k < fq.size() && k < int'(WORDS); k++) begin
            chk($sformatf("%s_fill%0d_addr", name, k), 64'(fq[k].addr), 64'(base + 16'(2 * k)));
            chk($sformatf("%s_fill%0d_data", name, k), 64'(fq[k].data), 64'(data_base + 16'(k)));
            chk($sformatf("%s_fill%0d_cyc", name, k), 64'(fq[k].cyc), 64'(t + 1 + int'(LATENCY) + k));
        end
    endtask

    typedef struct {
        logic        st_req;
        logic [15:0] st_addr;
        logic [15:0] st_data;
        logic        stray;
        logic        e_busy, e_en, e_wr, e_ack;
        logic [15:0] e_addr, e_wdata;
        logic        e_fill, e_done;
    } vec_t;

    function automatic vec_t mk(input logic sr, input logic [15:0] sa, input logic [15:0] sd,
                                input logic sv, input logic eb, input logic een, input logic ewr,
                                input logic eack, input logic [15:0] ea, input logic [15:0] ewd,
                                input logic ef, input logic ed);
        vec_t v;
        v.st_req = sr; v.st_addr = sa; v.st_data = sd; v.stray = sv;
        v.e_busy = eb; v.e_en = een; v.e_wr = ewr; v.e_ack = eack;
        v.e_addr = ea; v.e_wdata = ewd; v.e_fill = ef; v.e_done = ed;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   t, at, at_i, at_d, at_s;
        logic reached;

        vecs[0] = mk(1'b0, 16'h0000, 16'h0000, 1'b0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
        vecs[1] = mk(1'b0, 16'h0000, 16'h0000, 1'b1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
        vecs[2] = mk(1'b1, 16'h00F0, 16'hBEEF, 1'b0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
        vecs[3] = mk(1'b1, 16'h00F0, 16'hBEEF, 1'b1, 1, 1, 1, 1, 16'h00F0, 16'hBEEF, 0, 0);
        vecs[4] = mk(1'b0, 16'h0000, 16'h0000, 1'b0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
        vecs[5] = mk(1'b1, 16'h1234, 16'h5678, 1'b1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
        vecs[6] = mk(1'b1, 16'h1234, 16'h5678, 1'b1, 1, 1, 1, 1, 16'h1234, 16'h5678, 0, 0);
        vecs[7] = mk(1'b0, 16'h0000, 16'h0000, 1'b1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);

        i_miss = 0; d_miss = 0; st_req = 0; stray = 0;
        i_addr = 0; d_addr = 0; st_addr = 0; st_data = 0;
        data_base = 16'hA000;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Table: reset state, store cycles, stray valids in IDLE/STORE.
        for (int r = 0; r < 8; r++) begin
            @(posedge clk); #1;
            st_req = vecs[r].st_req; st_addr = vecs[r].st_addr;
            st_data = vecs[r].st_data; stray = vecs[r].stray;
            @(negedge clk);
            chk($sformatf("vec%0d", r),
                64'({busy, mif.en, mif.wr, st_ack, mif.addr, mif.wdata,
                     fill_i_we | fill_d_we, i_done | d_done}),
                64'({vecs[r].e_busy, vecs[r].e_en, vecs[r].e_wr, vecs[r].e_ack,
                     vecs[r].e_addr, vecs[r].e_wdata, vecs[r].e_fill, vecs[r].e_done}));
        end
        @(posedge clk); #1 stray = 0; st_req = 0;
        repeat (2) @(posedge clk);

        // I-miss block fill.
        #1 clear_q();
        i_miss = 1; i_addr = 16'h1236; t = cyc;
        wait_ev(1, "imiss_done", at);
        chk("imiss_done_cyc", 64'(at), 64'(t + 12));
        @(posedge clk); #1 i_miss = 0;
        chk("imiss_idle_after", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        check_fill(1'b0, 16'h1230, t, "imiss");
        chk("imiss_events", 64'(ev_q.size()), 64'd1);

        // Simultaneous requests: I, then D, then store.
        @(posedge clk); #1 clear_q();
        i_miss = 1; i_addr = 16'h0100; d_miss = 1; d_addr = 16'h4442;
        st_req = 1; st_addr = 16'h3000; st_data = 16'h1357; t = cyc;
        wait_ev(1, "sim_i", at_i);
        chk("sim_i_cyc", 64'(at_i), 64'(t + 12));
        @(posedge clk); #1 i_miss = 0;
        wait_ev(2, "sim_d", at_d);
        chk("sim_d_cyc", 64'(at_d), 64'(t + 25));
        @(posedge clk); #1 d_miss = 0;
        wait_ev(3, "sim_st", at_s);
        chk("sim_st_cyc", 64'(at_s), 64'(t + 27));
        @(posedge clk); #1 st_req = 0;
        repeat (5) @(posedge clk);
        chk("sim_nevents", 64'(ev_q.size()), 64'd3);
        if (ev_q.size() == 3) begin
            chk("sim_order", 64'({ev_q[0].addr[1:0], ev_q[1].addr[1:0], ev_q[2].addr[1:0]}),
                64'({2'd1, 2'd2, 2'd3}));
        end
        chk("sim_nwrites", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() == 1) chk("sim_store", 64'({wr_q[0].addr, wr_q[0].data}), 64'({16'h3000, 16'h1357}));
        chk("sim_nfill_i", 64'(fi_q.size()), 64'(WORDS));
        chk("sim_nfill_d", 64'(fd_q.size()), 64'(WORDS));
        if (fd_q.size() == WORDS) chk("sim_d_span", 64'({fd_q[0].addr, fd_q[WORDS-1].addr}), 64'({16'h4440, 16'h444E}));

        // Reset after three words of a D-fill, then a clean refill.
        #1 clear_q();
        d_miss = 1; d_addr = 16'h2000;
        reached = 1'b0;
        for (int n = 0; n < 40 && !reached; n++) begin
            @(posedge clk);
            if (fd_q.size() >= 3) reached = 1'b1;
        end
        chk("rst_three_words", 64'(reached), 64'd1);
        #2 rst_n = 1'b0; d_miss = 0;
        #1 chk("rst_outputs_zero",
               64'({st_ack, mif.en, mif.wr, mif.addr, mif.wdata, fill_i_we, fill_d_we,
                    fill_addr, fill_data, i_done, d_done, busy}), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1 clear_q();
        d_miss = 1; d_addr = 16'h2004; t = cyc;
        wait_ev(2, "rst_refill", at);
        chk("rst_refill_cyc", 64'(at), 64'(t + 12));
        @(posedge clk); #1 d_miss = 0;
        repeat (2) @(posedge clk);
        check_fill(1'b1, 16'h2000, t, "refill");

        // Block at the top of the address space.
        @(posedge clk); #1 clear_q();
        d_miss = 1; d_addr = 16'hFFFE; t = cyc;
        wait_ev(2, "wrap", at);
        chk("wrap_done_cyc", 64'(at), 64'(t + 12));
        @(posedge clk); #1 d_miss = 0;
        repeat (2) @(posedge clk);
        check_fill(1'b1, 16'hFFF0, t, "wrap");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
